bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Sequences ownership of the shared serial bus interconnect between NO_MASTERS masters.
//  - Accepts per-master requests, each carrying a target slave ID.
//  - Picks a winner round-robin and drives bus_state {master_sel, slave_sel} to the interconnect.
//  - Uses the interconnect's muxed slave ready to decide when the bus may be released.
// PARAMETERS
//  NO_MASTERS  2                         number of requesting masters
//  NO_SLAVES   3                         number of slaves; slave ID NO_SLAVES = "no slave" (idle)
//  S_ID_WIDTH  $clog2(NO_SLAVES+1)       slave ID width
//  M_ID_WIDTH  $clog2(NO_MASTERS)        master ID width
//  TIMEOUT     256                       max BUSY cycles per grant (used only with ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1                              single clock, rising edge
//  rstN         in   1                              asynchronous, active-low reset
//  req_M        in   1 [0:NO_MASTERS-1]             master requests / holds bus while high
//  slave_id_M   in   S_ID_WIDTH [0:NO_MASTERS-1]    requested slave, sampled at grant
//  grant_M      out  1 [0:NO_MASTERS-1]             one-hot grant, at most one high
//  bus_state    out  S_ID_WIDTH+M_ID_WIDTH          {master_sel, slave_sel} to interconnect
//  ready        in   1                              muxed slave ready from interconnect
//  busy         out  1                              high in any state except IDLE
//  timeout      out  1                              1-cycle pulse on forced revoke (0 without macro)
// BEHAVIOUR
//  Reset (rstN low, async):
//   - state=IDLE, grant_M all 0, busy=0, timeout=0.
//   - bus_state={'0, NO_SLAVES}, rr pointer=0, timeout counter=0.
//  Valid request: req_M[i]=1 and slave_id_M[i] < NO_SLAVES. Requests with out-of-range IDs are
//   masked and never granted.
//  IDLE:
//   - Picks the first valid requester starting at (last_winner+1) mod NO_MASTERS.
//   - On the next edge registers bus_state={i, slave_id_M[i]}, sets grant_M[i]=1, goes BUSY.
//   - Latency: req high at edge n -> grant/bus_state at edge n+1.
//  BUSY: grant held while req_M[winner]=1. When req_M[winner]=0:
//   - ready=1 -> RELEASE.
//   - ready=0 -> DRAIN.
//  DRAIN: grant_M cleared, bus_state unchanged (slave finishes); ready=1 -> RELEASE.
//  RELEASE (1 cycle):
//   - bus_state slave_sel=NO_SLAVES, master_sel unchanged.
//   - rr pointer=winner; -> IDLE.
//   - Guarantees one dead cycle between owners; no back-to-back handover.
//  Simultaneous requests: round-robin order only; no master wins twice while another valid
//   requester waits.
//  slave_id_M changes while granted are ignored (sampled once at grant).
//  Reset mid-transfer: immediate return to reset values; the interconnect sees idle slave_sel.
//  All state and outputs are registered (no combinational req->grant path).
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - Counter runs in BUSY, cleared on entry.
//   - On the count reaching TIMEOUT-1 with req still high: grant revoked, timeout pulses for 1
//     cycle, state -> DRAIN (then normal RELEASE).
//   - The revoked master must drop req before it is eligible again.
//  ARB_TIMEOUT_EN undefined: no counter; timeout tied 0; grant lasts until req drops.
// STRUCTURE
//  Package bus_pkg:
//   - arb_state_t enum {IDLE, BUSY, DRAIN, RELEASE}.
//   - Helper function packing {master_sel, slave_sel} into bus_state.
//  Sub-module rr_picker: combinational round-robin first-one search.
//   - in: req vector, pointer. out: valid, index.
//  FSM, bus_state register, grant register and timeout counter are in bus_arbiter.
// TESTING
//  1. Reset: rstN=0 mid-BUSY -> bus_state={0,3}, grant=0, busy=0 asynchronously.
//  2. Single req: M0 req, id=2 -> next edge grant_M[0]=1, bus_state={0,2}.
//     Drop req with ready=1 -> RELEASE (slave_sel=3) -> IDLE.
//  3. Contention: M0,M1 both req (ids 1,0) -> M0 wins first; after release, M1 wins with
//     bus_state={1,0}, not M0 again.
//  4. Drain: M1 drops req while ready=0 for 5 cycles -> grant 0, bus_state held 5 cycles,
//     then RELEASE.
//  5. Invalid ID: M0 id=3 and M1 id=1 -> only M1 granted; M0 alone is never granted.
//  6. Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): M0 holds req -> revoked after 8 BUSY cycles,
//     timeout pulse 1 cycle; M0 is not regranted until req drops.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the serial bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Packs {master_sel, slave_sel} into a word; callers truncate to their bus_state width.
  function automatic logic [31:0] pack_bus_state(input int master_sel,
                                                 input int slave_sel,
                                                 input int s_id_width);
    return (32'(master_sel) << s_id_width) | 32'(slave_sel);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin first-one search: scans from ptr_i+1 upward, wrapping, and returns the
// first set request bit. Purely combinational.
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          valid_o,
  output logic [PW-1:0] idx_o
);

  int cand;

  // Walk the candidates in rotation order; the last winner (ptr_i) is checked last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = PW'(cand);
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared serial bus interconnect.
// Flow: IDLE -> BUSY (grant held while req) -> [DRAIN while slave not ready] -> RELEASE -> IDLE.
// RELEASE drives the idle slave ID for one cycle so two owners never touch back to back.
// Optional feature: define ARB_TIMEOUT_EN to add a per-grant BUSY watchdog that revokes
// the grant after TIMEOUT cycles and pulses 'timeout'.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 256
`endif
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             req_M      [0:NO_MASTERS-1],
  input  logic [S_ID_WIDTH-1:0]            slave_id_M [0:NO_MASTERS-1],
  output logic                             grant_M    [0:NO_MASTERS-1],
  output logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state,
  input  logic                             ready,
  output logic                             busy,
  output logic                             timeout
);

  localparam int BW = S_ID_WIDTH + M_ID_WIDTH;

  arb_state_t             state_q, state_d;
  logic [BW-1:0]          bus_state_q, bus_state_d;
  logic [NO_MASTERS-1:0]  grant_q, grant_d;
  logic [M_ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic                   busy_q, busy_d;

  logic [NO_MASTERS-1:0]  req_vec;
  logic [NO_MASTERS-1:0]  valid_vec;
  logic                   pick_valid;
  logic [M_ID_WIDTH-1:0]  pick_idx;
  logic [S_ID_WIDTH-1:0]  pick_slave;
  logic [M_ID_WIDTH-1:0]  winner_m;
  logic                   winner_req;
  logic [BW-1:0]          idle_bus;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NO_MASTERS-1:0]  blocked_q, blocked_d;
  logic                   timeout_q, timeout_d;
  logic                   revoke;
`endif

  // Flatten requests and mask out-of-range slave IDs (and, with the watchdog, revoked masters).
  always_comb begin
    req_vec   = '0;
    valid_vec = '0;
    for (int i = 0; i < NO_MASTERS; i++) begin
      req_vec[i]   = req_M[i];
      valid_vec[i] = req_M[i] & (int'(slave_id_M[i]) < NO_SLAVES);
`ifdef ARB_TIMEOUT_EN
      valid_vec[i] = valid_vec[i] & ~blocked_q[i];
`endif
    end
  end

  rr_picker #(
    .N (NO_MASTERS),
    .PW(M_ID_WIDTH)
  ) u_picker (
    .req_i  (valid_vec),
    .ptr_i  (ptr_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  assign pick_slave = slave_id_M[pick_idx];
  assign winner_m   = bus_state_q[BW-1 -: M_ID_WIDTH];
  assign winner_req = req_vec[winner_m];
  assign idle_bus   = BW'(pack_bus_state(int'(winner_m), NO_SLAVES, S_ID_WIDTH));

  // FSM state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; owner release waits for the slave to report ready.
  always_comb begin
    state_d = state_q;
`ifdef ARB_TIMEOUT_EN
    revoke  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!winner_req) begin
          state_d = ready ? RELEASE : DRAIN;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DRAIN;
          revoke  = 1'b1;
`endif
        end else begin
          state_d = BUSY;
        end
      end
      DRAIN: begin
        if (ready) begin
          state_d = RELEASE;
        end else begin
          state_d = DRAIN;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output/datapath logic: next values of grant, bus_state, pointer and watchdog.
  always_comb begin
    grant_d     = grant_q;
    bus_state_d = bus_state_q;
    ptr_d       = ptr_q;
    busy_d      = (state_d != IDLE);
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = revoke;
    blocked_d   = blocked_q & req_vec;
`endif
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d[pick_idx] = 1'b1;
          bus_state_d = BW'(pack_bus_state(int'(pick_idx), int'(pick_slave), S_ID_WIDTH));
`ifdef ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else begin
          bus_state_d = bus_state_q;
        end
      end
      BUSY: begin
        if (state_d == BUSY) begin
          grant_d = grant_q;
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + CW'(1);
`endif
        end else begin
          grant_d = '0;
          if (state_d == RELEASE) begin
            bus_state_d = idle_bus;
          end else begin
            bus_state_d = bus_state_q;
          end
`ifdef ARB_TIMEOUT_EN
          if (revoke) begin
            blocked_d[winner_m] = 1'b1;
          end else begin
            blocked_d = blocked_d;
          end
`endif
        end
      end
      DRAIN: begin
        grant_d = '0;
        if (state_d == RELEASE) begin
          bus_state_d = idle_bus;
        end else begin
          bus_state_d = bus_state_q;
        end
      end
      RELEASE: begin
        grant_d = '0;
        ptr_d   = winner_m;
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  // Registered outputs and arbitration bookkeeping.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      grant_q     <= '0;
      bus_state_q <= BW'(pack_bus_state(0, NO_SLAVES, S_ID_WIDTH));
      ptr_q       <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      blocked_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      grant_q     <= grant_d;
      bus_state_q <= bus_state_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      blocked_q   <= blocked_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Unpack the one-hot grant onto the per-master port.
  always_comb begin
    for (int i = 0; i < NO_MASTERS; i++) begin
      grant_M[i] = grant_q[i];
    end
  end

  assign bus_state = bus_state_q;
  assign busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (2 masters, 3 slaves, bus_state = {m[0], s[1:0]}).
module tb_bus_arbiter;

  logic       clk;
  logic       rstN;
  logic       req_M      [0:1];
  logic [1:0] slave_id_M [0:1];
  logic       grant_M    [0:1];
  logic [2:0] bus_state;
  logic       ready;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       r0;
    logic       r1;
    logic [1:0] i0;
    logic [1:0] i1;
    logic       rdy;
    logic [1:0] g;    // {grant1, grant0}
    logic [2:0] bs;
    logic       bsy;
  } vec_t;

  vec_t tbl[$];

  bus_arbiter #(
    .NO_MASTERS(2),
    .NO_SLAVES (3)
`ifdef ARB_TIMEOUT_EN
    ,
    .TIMEOUT   (8)
`endif
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .req_M     (req_M),
    .slave_id_M(slave_id_M),
    .grant_M   (grant_M),
    .bus_state (bus_state),
    .ready     (ready),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [1:0] i0,
                       input logic [1:0] i1, input logic rdy);
    req_M[0] = r0; req_M[1] = r1;
    slave_id_M[0] = i0; slave_id_M[1] = i1;
    ready = rdy;
  endtask

  task automatic chk_all(input string nm, input logic [1:0] g, input logic [2:0] bs,
                         input logic bsy, input logic to);
    chk({nm, ".grant"},     {30'd0, grant_M[1], grant_M[0]}, {30'd0, g});
    chk({nm, ".bus_state"}, {29'd0, bus_state}, {29'd0, bs});
    chk({nm, ".busy"},      {31'd0, busy}, {31'd0, bsy});
    chk({nm, ".timeout"},   {31'd0, timeout}, {31'd0, to});
  endtask

  task automatic add(input logic r0, input logic r1, input logic [1:0] i0, input logic [1:0] i1,
                     input logic rdy, input logic [1:0] g, input logic [2:0] bs, input logic bsy);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.i0 = i0; v.i1 = i1; v.rdy = rdy;
    v.g = g; v.bs = bs; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  initial begin
    rstN = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 2'd0, 1'b1);

    //   r0    r1    i0    i1    rdy   grant  bus   busy
    // single M0 request, id=2; id change while granted is ignored
    add(1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 2'b01, 3'd2, 1'b1);
    add(1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 2'b01, 3'd2, 1'b1);
    add(1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 2'b01, 3'd2, 1'b1);
    add(1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'b00, 3'd3, 1'b1);   // RELEASE
    add(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'd3, 1'b0);   // IDLE, ptr=0
    // M1 drain: req drops with ready low for 5 cycles
    add(1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 2'b10, 3'd5, 1'b1);
    add(1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'b00, 3'd5, 1'b1);   // DRAIN 1
    add(1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'b00, 3'd5, 1'b1);
    add(1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'b00, 3'd5, 1'b1);
    add(1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'b00, 3'd5, 1'b1);
    add(1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'b00, 3'd5, 1'b1);   // DRAIN 5
    add(1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 2'b00, 3'd7, 1'b1);   // RELEASE {1,3}
    add(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'd7, 1'b0);   // IDLE, ptr=1
    // contention: ids 1,0; M0 first, then M1 even though M0 re-requests
    add(1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 2'b01, 3'd1, 1'b1);
    add(1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 2'b00, 3'd3, 1'b1);   // RELEASE
    add(1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 2'b00, 3'd3, 1'b0);   // IDLE, dead cycle
    add(1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 2'b10, 3'd4, 1'b1);   // M1 wins {1,0}
    add(1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 2'b00, 3'd7, 1'b1);   // RELEASE
    add(1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 2'b00, 3'd7, 1'b0);   // IDLE
    add(1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 2'b01, 3'd1, 1'b1);   // M0 again
    add(1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'b00, 3'd3, 1'b1);
    add(1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'b00, 3'd3, 1'b0);   // IDLE, ptr=0
    // invalid slave id on M0 is never granted
    add(1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 2'b00, 3'd3, 1'b0);
    add(1'b1, 1'b0, 2'd3, 2'd0, 1'b1, 2'b00, 3'd3, 1'b0);
    add(1'b1, 1'b1, 2'd3, 2'd1, 1'b1, 2'b10, 3'd5, 1'b1);
    add(1'b1, 1'b0, 2'd3, 2'd1, 1'b1, 2'b00, 3'd7, 1'b1);
    add(1'b1, 1'b0, 2'd3, 2'd1, 1'b1, 2'b00, 3'd7, 1'b0);   // IDLE, ptr=1
    add(1'b1, 1'b1, 2'd3, 2'd2, 1'b1, 2'b10, 3'd6, 1'b1);   // M0 masked despite priority
    add(1'b1, 1'b0, 2'd3, 2'd2, 1'b1, 2'b00, 3'd7, 1'b1);
    add(1'b1, 1'b0, 2'd3, 2'd2, 1'b1, 2'b00, 3'd7, 1'b0);
    add(1'b1, 1'b0, 2'd3, 2'd2, 1'b1, 2'b00, 3'd7, 1'b0);
    add(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'b00, 3'd7, 1'b0);

    // reset values
    #12;
    chk_all("reset", 2'b00, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    rstN = 1'b1;

    // table-driven vectors
    foreach (tbl[k]) begin
      drive(tbl[k].r0, tbl[k].r1, tbl[k].i0, tbl[k].i1, tbl[k].rdy);
      step();
      chk_all($sformatf("row%0d", k), tbl[k].g, tbl[k].bs, tbl[k].bsy, 1'b0);
    end

    // asynchronous reset in the middle of a grant
    drive(1'b1, 1'b0, 2'd2, 2'd0, 1'b1);
    step();
    chk_all("pre_rst", 2'b01, 3'd2, 1'b1, 1'b0);
    #3;
    rstN = 1'b0;
    req_M[0] = 1'b0;
    #1;
    chk_all("async_rst", 2'b00, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    rstN = 1'b1;

`ifdef ARB_TIMEOUT_EN
    // watchdog: M0 holds req; revoked after 8 BUSY cycles
    drive(1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
    step();
    chk_all("to_grant", 2'b01, 3'd0, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step();
      chk_all($sformatf("to_hold%0d", k), 2'b01, 3'd0, 1'b1, 1'b0);
    end
    step();
    chk_all("to_revoke", 2'b00, 3'd0, 1'b1, 1'b1);
    step();
    chk_all("to_release", 2'b00, 3'd3, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_all($sformatf("to_blocked%0d", k), 2'b00, 3'd3, 1'b0, 1'b0);
    end
    req_M[0] = 1'b0;
    step();
    chk_all("to_drop", 2'b00, 3'd3, 1'b0, 1'b0);
    req_M[0] = 1'b1;
    step();
    chk_all("to_regrant", 2'b01, 3'd0, 1'b1, 1'b0);
`else
    // no watchdog: grant persists while req stays high
    drive(1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
    step();
    chk_all("hold_grant", 2'b01, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk_all($sformatf("hold%0d", k), 2'b01, 3'd0, 1'b1, 1'b0);
    end
`endif
    req_M[0] = 1'b0;
    step();
    chk_all("end_release", 2'b00, 3'd3, 1'b1, 1'b0);
    step();
    chk_all("end_idle", 2'b00, 3'd3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
